// File: rtl/kf76489_pkg.sv
// rtl/kf76489_pkg.sv - shared types and constants for the KF76489 CPU write port
package kf76489_pkg;

  typedef enum logic [1:0] {IDLE, STROBE, BUSY} state_t;

  typedef struct packed {
    logic [1:0] channel;
    logic       is_attenuation;
  } reg_select_t;

  typedef struct packed {
    logic [2:0] freq_h;
    logic [2:0] freq_l;
    logic [3:0] atten;
    logic       noise;
  } strobe_t;

  localparam logic [1:0] NOISE_CHANNEL = 2'd3;
  localparam int         LATCH_BIT     = 7;

endpackage

// File: rtl/kf76489_command_decoder.sv
// rtl/kf76489_command_decoder.sv - maps a CPU byte and the latched register to one strobe and payload
module kf76489_command_decoder
  import kf76489_pkg::*;
(
  input  logic [7:0]  data,
  input  reg_select_t latched,
  output reg_select_t next_latched,
  output strobe_t     strobes,
  output logic [7:0]  payload
);

  reg_select_t sel;
  logic        is_latch;

  always_comb begin
    is_latch     = data[LATCH_BIT];
    next_latched = latched;
    strobes      = '0;
    payload      = 8'h00;
    if (is_latch)
      next_latched = reg_select_t'(data[6:4]);
    // A latch byte targets its own register; a data byte reuses the previous one
    sel = next_latched;
    if (sel.is_attenuation) begin
      strobes.atten[sel.channel] = 1'b1;
      payload = {data[3:0], 4'h0};
    end else if (sel.channel == NOISE_CHANNEL) begin
      strobes.noise = 1'b1;
      payload = {data[2:0], 5'h00};
    end else if (is_latch) begin
      strobes.freq_h[sel.channel] = 1'b1;
      payload = {data[3:0], 4'h0};
    end else begin
      strobes.freq_l[sel.channel] = 1'b1;
      payload = {data[5:0], 2'b00};
    end
  end

endmodule

// File: rtl/kf76489_bus_interface.sv
// rtl/kf76489_bus_interface.sv - CPU write port: edge-detected accept, one-cycle strobe, READY hold-off
module kf76489_bus_interface
  import kf76489_pkg::*;
#(
  parameter int READY_CYCLES = 32
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       clock_enable,
  input  logic       chip_enable_n,
  input  logic       write_enable_n,
  input  logic [7:0] data_bus,
  output logic       ready,
  output logic [7:0] internal_data_bus,
  output logic [2:0] write_frequency_h,
  output logic [2:0] write_frequency_l,
  output logic [3:0] write_attenuation,
  output logic       write_noise_control
);

  localparam logic [7:0] READY_LOAD = 8'(READY_CYCLES);

  state_t      state;
  logic        prev_active;
  logic [7:0]  counter;
  reg_select_t latched;
  reg_select_t next_latched;
  strobe_t     dec_strobes;
  strobe_t     strobe_q;
  logic [7:0]  payload;
  logic        write_active;
  logic        accept;

  assign write_active = ~chip_enable_n & ~write_enable_n;
  assign accept       = write_active & ~prev_active;

  kf76489_command_decoder u_decoder (
    .data         (data_bus),
    .latched      (latched),
    .next_latched (next_latched),
    .strobes      (dec_strobes),
    .payload      (payload)
  );

  // Strobes are registered on the accept edge so they are high exactly during the STROBE cycle
  always_ff @(posedge clock) begin
    if (reset) begin
      state             <= IDLE;
      ready             <= 1'b1;
      strobe_q          <= '0;
      internal_data_bus <= 8'h00;
      latched           <= '0;
      prev_active       <= 1'b1;
      counter           <= 8'h00;
    end else begin
      prev_active <= write_active;
      strobe_q    <= '0;
      case (state)
        IDLE: begin
          if (accept) begin
            strobe_q          <= dec_strobes;
            internal_data_bus <= payload;
            latched           <= next_latched;
            ready             <= 1'b0;
            state             <= STROBE;
          end
        end
        STROBE: begin
          counter <= READY_LOAD;
          state   <= BUSY;
        end
        BUSY: begin
          if (clock_enable) begin
            counter <= counter - 8'd1;
            if (counter == 8'd1) begin
              ready <= 1'b1;
              state <= IDLE;
            end
          end
        end
        default: begin
          ready <= 1'b1;
          state <= IDLE;
        end
      endcase
    end
  end

  assign write_frequency_h   = strobe_q.freq_h;
  assign write_frequency_l   = strobe_q.freq_l;
  assign write_attenuation   = strobe_q.atten;
  assign write_noise_control = strobe_q.noise;

endmodule

// File: tb/tb_kf76489_bus_interface.sv
// tb/tb_kf76489_bus_interface.sv - directed and random checks of the KF76489 write port
module tb_kf76489_bus_interface;

  localparam int RC = 32;

  logic       clock = 1'b0;
  logic       reset;
  logic       clock_enable;
  logic       chip_enable_n;
  logic       write_enable_n;
  logic [7:0] data_bus;
  logic       ready;
  logic [7:0] internal_data_bus;
  logic [2:0] write_frequency_h;
  logic [2:0] write_frequency_l;
  logic [3:0] write_attenuation;
  logic       write_noise_control;

  kf76489_bus_interface #(.READY_CYCLES(RC)) dut (
    .clock               (clock),
    .reset               (reset),
    .clock_enable        (clock_enable),
    .chip_enable_n       (chip_enable_n),
    .write_enable_n      (write_enable_n),
    .data_bus            (data_bus),
    .ready               (ready),
    .internal_data_bus   (internal_data_bus),
    .write_frequency_h   (write_frequency_h),
    .write_frequency_l   (write_frequency_l),
    .write_attenuation   (write_attenuation),
    .write_noise_control (write_noise_control)
  );

  always #5 clock = ~clock;

  // Strobe vector layout: [10:8] freq_h, [7:5] freq_l, [4:1] attenuation, [0] noise
  logic [10:0] strb;
  assign strb = {write_frequency_h, write_frequency_l, write_attenuation, write_noise_control};

  int n_cmp = 0;
  int n_bad = 0;
  int n_acc = 0;
  int n_strobe = 0;

  logic        m_busy;
  logic        m_first;
  logic        m_prev;
  int          m_ticks;
  logic [2:0]  m_lat;
  logic [10:0] exp_strb;
  logic [7:0]  exp_bus;
  logic [10:0] last_strb;
  logic [7:0]  last_bus;
  int          low;

  function automatic void predict(input logic [7:0] d, inout logic [2:0] lat,
                                  output logic [10:0] s, output logic [7:0] b);
    int   ch;
    logic attn;
    if (d[7]) lat = d[6:4];
    ch   = int'(lat[2:1]);
    attn = lat[0];
    s    = '0;
    if (attn) begin
      s[1 + ch] = 1'b1;
      b = {d[3:0], 4'h0};
    end else if (ch == 3) begin
      s[0] = 1'b1;
      b = {d[2:0], 5'h00};
    end else if (d[7]) begin
      s[8 + ch] = 1'b1;
      b = {d[3:0], 4'h0};
    end else begin
      s[5 + ch] = 1'b1;
      b = {d[5:0], 2'b00};
    end
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic step(input logic ce, input logic cen, input logic wen, input logic [7:0] d);
    logic        act;
    logic [10:0] ns;
    ns = '0;
    clock_enable   = ce;
    chip_enable_n  = cen;
    write_enable_n = wen;
    data_bus       = d;
    act = !cen && !wen;
    if (!m_busy) begin
      if (act && !m_prev) begin
        predict(d, m_lat, ns, exp_bus);
        m_busy  = 1'b1;
        m_first = 1'b1;
        m_ticks = 0;
        n_acc++;
      end
    end else if (m_first) begin
      m_first = 1'b0;
    end else if (ce) begin
      m_ticks++;
      if (m_ticks == RC) m_busy = 1'b0;
    end
    m_prev   = act;
    exp_strb = ns;
    @(posedge clock);
    #1;
    if (strb != 11'd0) n_strobe++;
    check("ready", 32'(ready), 32'(!m_busy));
    check("strobe", 32'(strb), 32'(exp_strb));
    check("bus", 32'(internal_data_bus), 32'(exp_bus));
    check("onehot", 32'($countones(strb) <= 1), 32'd1);
  endtask

  task automatic do_reset(input logic cen, input logic wen);
    reset          = 1'b1;
    clock_enable   = 1'b1;
    chip_enable_n  = cen;
    write_enable_n = wen;
    data_bus       = 8'h00;
    @(posedge clock);
    #1;
    reset    = 1'b0;
    m_busy   = 1'b0;
    m_first  = 1'b0;
    m_prev   = 1'b1;
    m_ticks  = 0;
    m_lat    = 3'b000;
    exp_strb = '0;
    exp_bus  = 8'h00;
    check("reset_ready", 32'(ready), 32'd1);
    check("reset_strobe", 32'(strb), 32'd0);
    check("reset_bus", 32'(internal_data_bus), 32'd0);
  endtask

  // Accept one byte, then idle until ready returns; glitch_at injects a write edge while busy
  task automatic write_and_wait(input logic [7:0] d, input int rate, input int glitch_at,
                                output int low_cycles);
    logic ce;
    bit   done;
    done = 0;
    step(1'b1, 1'b0, 1'b0, d);
    last_strb  = strb;
    last_bus   = internal_data_bus;
    low_cycles = 32'(!ready);
    for (int j = 0; j < 400; j++) begin
      ce = (rate == 1) ? 1'b1 : (((1 + j) % rate) == 1);
      if (j == glitch_at) step(ce, 1'b0, 1'b0, 8'h8F);
      else                step(ce, 1'b1, 1'b1, 8'h00);
      if (ready) begin
        done = 1;
        break;
      end
      low_cycles++;
    end
    if (!done) check("ready_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    do_reset(1'b1, 1'b1);
    step(1'b1, 1'b1, 1'b1, 8'h00);

    write_and_wait(8'h8A, 1, -1, low);
    check("8A_strobe", 32'(last_strb), 32'h100);
    check("8A_bus", 32'(last_bus), 32'hA0);
    check("8A_low", 32'(low), 32'd33);
    write_and_wait(8'h15, 1, -1, low);
    check("15_strobe", 32'(last_strb), 32'h020);
    check("15_bus", 32'(last_bus), 32'h54);
    check("15_low", 32'(low), 32'd33);

    write_and_wait(8'hDF, 1, -1, low);
    check("DF_strobe", 32'(last_strb), 32'h008);
    check("DF_bus", 32'(last_bus), 32'hF0);
    write_and_wait(8'h03, 1, -1, low);
    check("03_strobe", 32'(last_strb), 32'h008);
    check("03_bus", 32'(last_bus), 32'h30);

    write_and_wait(8'hE5, 1, -1, low);
    check("E5_strobe", 32'(last_strb), 32'h001);
    check("E5_bus", 32'(last_bus), 32'hA0);
    write_and_wait(8'h06, 1, -1, low);
    check("06_strobe", 32'(last_strb), 32'h001);
    check("06_bus", 32'(last_bus), 32'hC0);

    write_and_wait(8'h90, 1, 6, low);
    check("busy_edge_low", 32'(low), 32'd33);
    write_and_wait(8'h91, 4, -1, low);
    check("quarter_rate_low", 32'(low), 32'd129);
    check("quarter_rate_bus", 32'(last_bus), 32'h10);

    step(1'b1, 1'b0, 1'b0, 8'hC3);
    check("C3_strobe", 32'(strb), 32'h400);
    for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 1'b0, 8'hC3);
    do_reset(1'b0, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b0, 8'h3F);
    check("held_no_strobe", 32'(strb), 32'd0);
    step(1'b1, 1'b1, 1'b1, 8'h00);
    write_and_wait(8'h3F, 1, -1, low);
    check("3F_strobe", 32'(last_strb), 32'h020);
    check("3F_bus", 32'(last_bus), 32'hFC);

    n_acc = 0;
    n_strobe = 0;
    for (int i = 0; i < 4000; i++)
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           8'($urandom));
    check("random_strobe_count", 32'(n_strobe), 32'(n_acc));
    check("random_some_writes", 32'(n_acc > 10), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
